noip_ctrl_axil_regs: RTL and testbench



---
 rtl/noip_ctrl_axil_regs.sv | 192 +++++++++++++++++++
 tb/tb_noip_ctrl_axil_regs.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noip_ctrl_axil_regs.sv
// AXI4-Lite register bank: RW control words with byte strobes and a per-register
// write pulse, RO status words, and SLVERR/DECERR for illegal or unmapped accesses.
module noip_ctrl_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_CTRL         = 4,
  parameter int C_NUM_STAT         = 4,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_CTRL_RST_VAL = '0
) (
  input  logic                                  S_AXI_ACLK,
  input  logic                                  S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
  input  logic [2:0]                            S_AXI_AWPROT,
  input  logic                                  S_AXI_AWVALID,
  output logic                                  S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
  input  logic                                  S_AXI_WVALID,
  output logic                                  S_AXI_WREADY,
  output logic [1:0]                            S_AXI_BRESP,
  output logic                                  S_AXI_BVALID,
  input  logic                                  S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
  input  logic [2:0]                            S_AXI_ARPROT,
  input  logic                                  S_AXI_ARVALID,
  output logic                                  S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
  output logic [1:0]                            S_AXI_RRESP,
  output logic                                  S_AXI_RVALID,
  input  logic                                  S_AXI_RREADY,
  input  logic [((C_NUM_STAT > 0) ? C_NUM_STAT : 1)*C_S_AXI_DATA_WIDTH-1:0] stat_in,
  output logic [C_NUM_CTRL*C_S_AXI_DATA_WIDTH-1:0] ctrl_out,
  output logic [C_NUM_CTRL-1:0]                 ctrl_wr_pulse
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int NB     = DW / 8;
  localparam int LSB    = $clog2(NB);
  localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
  localparam int WORD_W = ADDR_W - LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {TGT_CTRL, TGT_STAT, TGT_NONE} tgt_e;

  function automatic int word_index(input logic [WORD_W-1:0] word);
    return int'(word);
  endfunction

  function automatic tgt_e target_of(input int idx);
    if (idx < C_NUM_CTRL)              return TGT_CTRL;
    if (idx < C_NUM_CTRL + C_NUM_STAT) return TGT_STAT;
    return TGT_NONE;
  endfunction

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] upd,
                                                input logic [NB-1:0] strb);
    logic [DW-1:0] res;
    res = cur;
    for (int b = 0; b < NB; b++)
      if (strb[b]) res[b*8 +: 8] = upd[b*8 +: 8];
    return res;
  endfunction

  logic                  aw_held_p0, w_held_p0;
  logic [WORD_W-1:0]     aw_word_p0;
  logic [DW-1:0]         w_data_p0;
  logic [NB-1:0]         w_strb_p0;
  logic                  bvalid_p1;
  logic [1:0]            bresp_p1;
  logic [C_NUM_CTRL-1:0] wr_pulse_p1;
  logic [DW-1:0]         ctrl_q [C_NUM_CTRL];
  logic                  rvalid_p1;
  logic [DW-1:0]         rdata_p1;
  logic [1:0]            rresp_p1;

  logic                  commit;
  int                    wr_idx, rd_idx;
  tgt_e                  wr_tgt, rd_tgt;
  logic [C_NUM_CTRL-1:0] wr_onehot;
  logic [1:0]            wr_resp;
  logic [DW-1:0]         rd_word;
  logic                  unused_ok;

  // Readies are forced low during reset so nothing is accepted while state clears.
  assign S_AXI_AWREADY = !aw_held_p0 && !S_AXI_ARESET;
  assign S_AXI_WREADY  = !w_held_p0  && !S_AXI_ARESET;
  assign S_AXI_ARREADY = !rvalid_p1  && !S_AXI_ARESET;
  assign commit        = aw_held_p0 && w_held_p0 && !bvalid_p1;

  assign wr_idx = word_index(aw_word_p0);
  assign wr_tgt = target_of(wr_idx);
  assign rd_idx = word_index(S_AXI_ARADDR[ADDR_W-1:LSB]);
  assign rd_tgt = target_of(rd_idx);

  always_comb begin
    wr_onehot = '0;
    for (int k = 0; k < C_NUM_CTRL; k++)
      if (wr_idx == k) wr_onehot[k] = 1'b1;
    case (wr_tgt)
      TGT_CTRL: wr_resp = RESP_OKAY;
      TGT_STAT: wr_resp = RESP_SLVERR;
      default:  wr_resp = RESP_DECERR;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < C_NUM_CTRL; k++)
      if (rd_idx == k) rd_word = ctrl_q[k];
    for (int k = 0; k < C_NUM_STAT; k++)
      if (rd_idx == C_NUM_CTRL + k) rd_word = stat_in[k*DW +: DW];
  end

  // Stage p0: independent one-deep AW / W holding registers
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_AWVALID && S_AXI_AWREADY) aw_word_p0 <= S_AXI_AWADDR[ADDR_W-1:LSB];
    if (S_AXI_WVALID && S_AXI_WREADY) begin
      w_data_p0 <= S_AXI_WDATA;
      w_strb_p0 <= S_AXI_WSTRB;
    end
  end

  // Stage p1: commit sets the B response and the write pulse
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_held_p0  <= 1'b0;
      w_held_p0   <= 1'b0;
      bvalid_p1   <= 1'b0;
      bresp_p1    <= RESP_OKAY;
      wr_pulse_p1 <= '0;
    end else begin
      wr_pulse_p1 <= '0;
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_held_p0 <= 1'b1;
      if (S_AXI_WVALID && S_AXI_WREADY)   w_held_p0  <= 1'b1;
      if (commit) begin
        aw_held_p0  <= 1'b0;
        w_held_p0   <= 1'b0;
        bvalid_p1   <= 1'b1;
        bresp_p1    <= wr_resp;
        wr_pulse_p1 <= wr_onehot;
      end else if (bvalid_p1 && S_AXI_BREADY) begin
        bvalid_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    for (int k = 0; k < C_NUM_CTRL; k++) begin
      if (S_AXI_ARESET)
        ctrl_q[k] <= C_CTRL_RST_VAL;
      else if (commit && wr_onehot[k])
        ctrl_q[k] <= merge_bytes(ctrl_q[k], w_data_p0, w_strb_p0);
    end
  end

  // Stage p1: read data registered at the AR handshake
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rvalid_p1 <= 1'b0;
      rdata_p1  <= '0;
      rresp_p1  <= RESP_OKAY;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rvalid_p1 <= 1'b1;
      rdata_p1  <= rd_word;
      rresp_p1  <= (rd_tgt == TGT_NONE) ? RESP_DECERR : RESP_OKAY;
    end else if (rvalid_p1 && S_AXI_RREADY) begin
      rvalid_p1 <= 1'b0;
    end
  end

  generate
    for (genvar g = 0; g < C_NUM_CTRL; g++) begin : g_ctrl_out
      assign ctrl_out[g*DW +: DW] = ctrl_q[g];
    end
  endgenerate

  assign S_AXI_BVALID  = bvalid_p1;
  assign S_AXI_BRESP   = bresp_p1;
  assign S_AXI_RVALID  = rvalid_p1;
  assign S_AXI_RDATA   = rdata_p1;
  assign S_AXI_RRESP   = rresp_p1;
  assign ctrl_wr_pulse = wr_pulse_p1;

  // Protection bits and sub-word address bits carry no meaning here.
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0],
                       S_AXI_ARADDR[LSB-1:0], stat_in};

endmodule

// File: tb/tb_noip_ctrl_axil_regs.sv
// Randomized bench for noip_ctrl_axil_regs with a word-array reference model,
// plus directed ordering, backpressure, concurrency and reset scenarios.
module tb_noip_ctrl_axil_regs;

  localparam int NC = 4;
  localparam int NS = 4;
  localparam logic [31:0] RST_VAL = 32'hC0DE_0001;

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] stat_in, ctrl_out;
  logic [3:0]   ctrl_wr_pulse;

  logic [31:0]  ctrl_m [NC];
  logic [31:0]  stat_m [NS];
  int           pulse_exp [NC];
  int           pulse_seen [NC];
  int           n_chk = 0;
  int           n_pass = 0;

  assign stat_in = {stat_m[3], stat_m[2], stat_m[1], stat_m[0]};

  noip_ctrl_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32), .C_NUM_CTRL(NC), .C_NUM_STAT(NS),
    .C_S_AXI_ADDR_WIDTH(7), .C_CTRL_RST_VAL(RST_VAL)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .stat_in(stat_in), .ctrl_out(ctrl_out), .ctrl_wr_pulse(ctrl_wr_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    for (int k = 0; k < NC; k++)
      if (ctrl_wr_pulse[k] === 1'b1) pulse_seen[k]++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  // Reference model: registers are plain words addressed by addr/4.
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [6:0] a);
    int idx = int'(a) / 4;
    if (idx < NC) return 2'b00;
    if (idx < NC + NS) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [6:0] a);
    return (int'(a) / 4 < NC + NS) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [6:0] a);
    int idx = int'(a) / 4;
    if (idx < NC) return ctrl_m[idx];
    if (idx < NC + NS) return stat_m[idx - NC];
    return 32'h0;
  endfunction

  function automatic logic [3:0] exp_pulse(input logic [6:0] a);
    int idx = int'(a) / 4;
    return (idx < NC) ? 4'(1 << idx) : 4'h0;
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a) / 4;
    if (idx < NC) begin
      ctrl_m[idx] = (ctrl_m[idx] & ~strb_mask(s)) | (d & strb_mask(s));
      pulse_exp[idx]++;
    end
  endtask

  task automatic check_ctrl_out(input string tag);
    for (int k = 0; k < NC; k++)
      check($sformatf("%s ctrl_out[%0d]", tag, k), 64'(ctrl_out[32*k +: 32]), 64'(ctrl_m[k]));
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    check("readies in reset", {61'h0, awready, wready, arready}, 64'h0);
    rst = 1'b0;
    for (int k = 0; k < NC; k++) ctrl_m[k] = RST_VAL;
    #1;
    check("readies after reset", {61'h0, awready, wready, arready}, 64'h7);
    check("valids after reset", {62'h0, bvalid, rvalid}, 64'h0);
    check("resp/data after reset", {28'h0, bresp, rresp, rdata}, 64'h0);
    check("pulse after reset", 64'(ctrl_wr_pulse), 64'h0);
    check_ctrl_out("reset");
  endtask

  task automatic drive_aw(input logic [6:0] a, input int dly);
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a; awprot = 3'($urandom); awvalid = 1'b1;
    while (!awready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("aw handshake timeout", 64'h1, 64'h0);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("w handshake timeout", 64'h1, 64'h0);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic wait_b(input logic [1:0] exp, input int stall);
    int n = 0;
    logic stable = 1'b1;
    logic [1:0] first;
    while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("b wait timeout", 64'h1, 64'h0);
    first = bresp;
    repeat (stall) begin
      @(posedge clk); #1;
      if (bvalid !== 1'b1 || bresp !== first) stable = 1'b0;
    end
    check("b stable under stall", 64'(stable), 64'h1);
    check("bresp", 64'(bresp), 64'(exp));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid cleared", 64'(bvalid), 64'h0);
  endtask

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int stall);
    fork
      drive_aw(a, awd);
      drive_w(d, s, wd);
    join
    check($sformatf("bvalid before commit @%0h", a), 64'(bvalid), 64'h0);
    @(posedge clk); #1;
    model_write(a, d, s);
    check($sformatf("bvalid after commit @%0h", a), 64'(bvalid), 64'h1);
    check($sformatf("pulse @%0h", a), 64'(ctrl_wr_pulse), 64'(exp_pulse(a)));
    check("readies back high", {62'h0, awready, wready}, 64'h3);
    check_ctrl_out($sformatf("wr@%0h", a));
    wait_b(exp_bresp(a), stall);
  endtask

  task automatic do_read(input logic [6:0] a, input int stall);
    int n = 0;
    logic stable = 1'b1;
    logic [31:0] d0;
    araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
    while (!arready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("ar handshake timeout", 64'h1, 64'h0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check($sformatf("rvalid @%0h", a), 64'(rvalid), 64'h1);
    d0 = rdata;
    repeat (stall) begin
      @(posedge clk); #1;
      if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0) stable = 1'b0;
    end
    check("r stable under stall", 64'(stable), 64'h1);
    check($sformatf("rdata @%0h", a), 64'(rdata), 64'(exp_rdata(a)));
    check($sformatf("rresp @%0h", a), 64'(rresp), 64'(exp_rresp(a)));
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    logic [31:0] old_val;
    logic [6:0]  a;
    int          sel;
    rst = 1'b1; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int k = 0; k < NS; k++) stat_m[k] = 32'h0;
    for (int k = 0; k < NC; k++) begin pulse_exp[k] = 0; pulse_seen[k] = 0; end
    do_reset(3);

    for (int k = 0; k < NC; k++) axi_write(7'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0);
    for (int k = 0; k < NC; k++) do_read(7'(4 * k), 0);

    axi_write(7'h00, 32'hAABB_CCDD, 4'b1111, 0, 0, 0);
    axi_write(7'h00, 32'h1122_3344, 4'b0101, 0, 0, 0);
    do_read(7'h00, 0);
    check("strobe merge", 64'(ctrl_out[31:0]), 64'hAA22_CC44);

    stat_m[0] = 32'hDEAD_BEEF;
    do_read(7'h10, 1);
    axi_write(7'h10, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
    do_read(7'h10, 0);
    do_read(7'h7C, 0);
    axi_write(7'h7C, 32'h1234_5678, 4'hF, 1, 0, 2);

    // W leads AW by 3 cycles; a second write is held while B is stalled.
    fork
      drive_aw(7'h08, 3);
      drive_w(32'h0000_0A0A, 4'hF, 0);
    join
    @(posedge clk); #1;
    model_write(7'h08, 32'h0000_0A0A, 4'hF);
    check("bp first bvalid", 64'(bvalid), 64'h1);
    awaddr = 7'h0C; awvalid = 1'b1; wdata = 32'h0000_0B0B; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    begin
      logic held_ok = 1'b1;
      repeat (5) begin
        if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1 || bresp !== 2'b00)
          held_ok = 1'b0;
        @(posedge clk); #1;
      end
      check("bp readies low while B pending", 64'(held_ok), 64'h1);
    end
    check_ctrl_out("bp second not yet committed");
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
    check("bp bvalid drop", 64'(bvalid), 64'h0);
    @(posedge clk); #1;
    model_write(7'h0C, 32'h0000_0B0B, 4'hF);
    check("bp second bvalid", 64'(bvalid), 64'h1);
    check_ctrl_out("bp second committed");
    wait_b(2'b00, 0);

    // AR handshake on the same edge as a commit to the same word.
    old_val = ctrl_m[1];
    awaddr = 7'h04; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; araddr = 7'h04; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("concurrent rvalid", 64'(rvalid), 64'h1);
    check("concurrent rdata old", 64'(rdata), 64'(old_val));
    check("concurrent old is 0x2", 64'(old_val), 64'h2);
    check("concurrent bvalid", 64'(bvalid), 64'h1);
    model_write(7'h04, 32'h55, 4'hF);
    rready = 1'b1; bready = 1'b1; @(posedge clk); #1; rready = 1'b0; bready = 1'b0;
    do_read(7'h04, 0);

    // Reset while AW is held and W has not yet arrived.
    awaddr = 7'h00; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("aw held before reset", 64'(awready), 64'h0);
    do_reset(2);
    wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no B after reset drop", 64'(bvalid), 64'h0);
    check_ctrl_out("post reset no commit");
    awaddr = 7'h00; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(posedge clk); #1;
    model_write(7'h00, 32'h7777_7777, 4'hF);
    check("held W commits with fresh AW", 64'(bvalid), 64'h1);
    wait_b(2'b00, 0);
    axi_write(7'h04, 32'hCAFE_0042, 4'hF, 0, 0, 0);
    do_read(7'h04, 0);

    for (int it = 0; it < 150; it++) begin
      for (int k = 0; k < NS; k++) stat_m[k] = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      a = 7'(4 * $urandom_range(0, NC - 1));
      else if (sel < 8) a = 7'(4 * $urandom_range(NC, NC + NS - 1));
      else              a = 7'(4 * $urandom_range(NC + NS, 31));
      a = a | 7'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        do_read(a, int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    for (int k = 0; k < NC; k++)
      check($sformatf("pulse count[%0d]", k), 64'(pulse_seen[k]), 64'(pulse_exp[k]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
